// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches instructions over a req/ack handshake
// and holds them in IR for the control block until Advance or Redirect.
module instr_fetch_unit #(
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  output logic                 MemReq,
  output logic [PC_WIDTH-1:0]  MemAddr,
  input  logic                 MemAck,
  input  logic [31:0]          MemRdata,
  input  logic                 Advance,
  input  logic                 Redirect,
  input  logic [PC_WIDTH-1:0]  Target,
  output logic                 InstrValid,
  output logic [PC_WIDTH-1:0]  PCOut,
  output logic [6:0]           Opcode,
  output logic [4:0]           Rd,
  output logic [2:0]           Funct3,
  output logic [4:0]           Rs1,
  output logic [4:0]           Rs2,
  output logic [6:0]           Funct7,
  output logic                 AlignErr,
  output logic [CNT_WIDTH-1:0] InstrCount
);
  typedef enum logic [1:0] {S_REQ, S_DROP, S_VALID} state_t;
  state_t               r_state, w_state_nxt;
  logic                 r_live;
  logic [PC_WIDTH-1:0]  r_pc, r_pend, w_pc_nxt, w_pend_nxt, w_tgt;
  logic [31:0]          r_ir, w_ir_nxt;
  logic                 r_align;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_ack, w_adv;
  assign w_tgt      = {Target[PC_WIDTH-1:2], 2'b00};
  assign MemReq     = r_live && (r_state != S_VALID);
  assign w_ack      = MemReq && MemAck;
  assign w_adv      = (r_state == S_VALID) && Advance;
  assign InstrValid = (r_state == S_VALID);
  assign MemAddr    = r_pc;
  assign PCOut      = r_pc;
  assign {Funct7, Rs2, Rs1, Funct3, Rd, Opcode} = r_ir;
  assign AlignErr   = r_align;
  assign InstrCount = r_cnt;
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_pend_nxt  = r_pend;
    if (r_live) begin
      unique case (r_state)
        S_REQ: begin
          // a redirect racing the ack discards the word and refetches at once
          if (Redirect && w_ack) w_pc_nxt = w_tgt;
          else if (Redirect) begin
            w_pend_nxt  = w_tgt;
            w_state_nxt = S_DROP;
          end else if (w_ack) begin
            w_ir_nxt    = MemRdata;
            w_state_nxt = S_VALID;
          end
        end
        S_DROP: begin
          if (w_ack) begin
            w_pc_nxt    = Redirect ? w_tgt : r_pend;
            w_state_nxt = S_REQ;
          end else if (Redirect) w_pend_nxt = w_tgt;
        end
        S_VALID: begin
          if (Redirect || Advance) begin
            w_pc_nxt    = Redirect ? w_tgt : r_pc + PC_WIDTH'(4);
            w_state_nxt = S_REQ;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_REQ;
      r_live  <= 1'b0;
      r_pc    <= RESET_PC;
      r_pend  <= RESET_PC;
      r_ir    <= 32'h0000_0013;
      r_align <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_pc    <= w_pc_nxt;
      r_pend  <= w_pend_nxt;
      r_ir    <= w_ir_nxt;
      r_align <= r_live && Redirect && (Target[1:0] != 2'b00);
      r_cnt   <= r_cnt + CNT_WIDTH'(w_adv);
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scoreboard bench for instr_fetch_unit with a
// programmable-latency instruction memory responder.
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MemReq, MemAck = 1'b0;
  logic [15:0] MemAddr, Target = '0, PCOut;
  logic [31:0] MemRdata = '0;
  logic        Advance = 1'b0, Redirect = 1'b0;
  logic        InstrValid, AlignErr;
  logic [6:0]  Opcode, Funct7;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [2:0]  Funct3;
  logic [15:0] InstrCount;
  typedef struct {logic [15:0] pc; logic [31:0] ir;} exp_t;
  exp_t        sb[$];
  logic [31:0] mem [64];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  instr_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemRdata(MemRdata), .Advance(Advance),
    .Redirect(Redirect), .Target(Target), .InstrValid(InstrValid),
    .PCOut(PCOut), .Opcode(Opcode), .Rd(Rd), .Funct3(Funct3), .Rs1(Rs1),
    .Rs2(Rs2), .Funct7(Funct7), .AlignErr(AlignErr), .InstrCount(InstrCount)
  );
  always #5 CLK = ~CLK;
  // memory answers after ack_delay request cycles without ack
  always @(negedge CLK) begin
    if (MemReq && wait_cnt == ack_delay) begin
      MemAck   = 1'b1;
      MemRdata = mem[MemAddr[7:2]];
      wait_cnt = 0;
    end else begin
      MemAck   = 1'b0;
      MemRdata = 32'hDEAD_BEEF;
      wait_cnt = MemReq ? wait_cnt + 1 : 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [15:0] pc);
    sb.push_back('{pc: pc, ir: mem[pc[7:2]]});
  endtask
  task automatic wait_valid(input string tag);
    exp_t e;
    for (int k = 0; k < 20 && !InstrValid; k++) @(negedge CLK);
    chk({tag, "_valid"}, 32'(InstrValid), 32'd1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_pc"}, 32'(PCOut), 32'(e.pc));
      chk({tag, "_ir"}, {Funct7, Rs2, Rs1, Funct3, Rd, Opcode}, e.ir);
    end
  endtask
  task automatic advance();
    Advance = 1'b1;
    @(negedge CLK);
    Advance = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7) | (32'(i) << 20);
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0000_A103;
    mem[2] = 32'h0020_A223;
    mem[3] = 32'h0020_81B3;
    repeat (2) @(negedge CLK);
    chk("rst_memreq", 32'(MemReq), 0);
    chk("rst_valid", 32'(InstrValid), 0);
    chk("rst_cnt", 32'(InstrCount), 0);
    chk("rst_align", 32'(AlignErr), 0);
    chk("rst_nop", 32'(Opcode), 32'h13);
    push(16'h0000);
    Reset = 1'b1;
    @(negedge CLK);
    chk("t1_req", 32'(MemReq), 1);
    chk("t1_addr", 32'(MemAddr), 0);
    wait_valid("t1");
    chk("t1_rd", 32'(Rd), 1);
    chk("t1_rs1", 32'(Rs1), 0);
    chk("t1_f3", 32'(Funct3), 0);
    chk("t1_cnt", 32'(InstrCount), 0);
    push(16'h0004);
    advance();
    wait_valid("t2a");
    chk("t2a_op", 32'(Opcode), 32'h03);
    push(16'h0008);
    advance();
    wait_valid("t2b");
    chk("t2b_op", 32'(Opcode), 32'h23);
    push(16'h000C);
    advance();
    wait_valid("t2c");
    chk("t2c_op", 32'(Opcode), 32'h33);
    chk("t2_cnt", 32'(InstrCount), 3);
    ack_delay = 4;
    push(16'h0010);
    advance();
    for (int c = 0; c < 4; c++) begin
      chk("t3_req", 32'(MemReq), 1);
      chk("t3_addr", 32'(MemAddr), 32'h10);
      chk("t3_valid", 32'(InstrValid), 0);
      chk("t3_ir_hold", 32'(Opcode), 32'h33);
      @(negedge CLK);
    end
    wait_valid("t3");
    ack_delay = 3;
    push(16'h0040);
    advance();
    Redirect = 1'b1;
    Target = 16'h0040;
    @(negedge CLK);
    Redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t4_req", 32'(MemReq), 1);
      chk("t4_old_addr", 32'(MemAddr), 32'h14);
      @(negedge CLK);
    end
    chk("t4_new_addr", 32'(MemAddr), 32'h40);
    chk("t4_valid", 32'(InstrValid), 0);
    wait_valid("t4");
    ack_delay = 0;
    push(16'h0020);
    Advance = 1'b1;
    Redirect = 1'b1;
    Target = 16'h0022;
    @(negedge CLK);
    Advance = 1'b0;
    Redirect = 1'b0;
    chk("t5_align", 32'(AlignErr), 1);
    chk("t5_addr", 32'(MemAddr), 32'h20);
    chk("t5_valid", 32'(InstrValid), 0);
    chk("t5_cnt", 32'(InstrCount), 6);
    @(negedge CLK);
    chk("t5_align_pulse", 32'(AlignErr), 0);
    wait_valid("t5");
    push(16'hFFFC);
    Redirect = 1'b1;
    Target = 16'hFFFC;
    @(negedge CLK);
    Redirect = 1'b0;
    chk("t6_align", 32'(AlignErr), 0);
    wait_valid("t6");
    ack_delay = 5;
    advance();
    chk("t6_wrap", 32'(MemAddr), 0);
    chk("t6_req", 32'(MemReq), 1);
    chk("t6_cnt", 32'(InstrCount), 7);
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    chk("t6_rst_req", 32'(MemReq), 0);
    chk("t6_rst_valid", 32'(InstrValid), 0);
    chk("t6_rst_cnt", 32'(InstrCount), 0);
    ack_delay = 0;
    push(16'h0000);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    chk("t6_refetch", 32'(MemAddr), 0);
    wait_valid("t6r");
    chk("t6r_cnt", 32'(InstrCount), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
